// File: rtl/leaf_port_pkg.sv
// Shared definitions for leaf-shell stream ports: payload width, vld/ack transfer rule,
// and the occupancy-update encoding used by the port fifos.
package leaf_port_pkg;

  localparam int unsigned PAYLOAD_BITS_DEFAULT = 32;

  // A word moves on any cycle where both handshake signals are at these levels.
  localparam logic XFER_VLD = 1'b1;
  localparam logic XFER_ACK = 1'b1;

  typedef logic [PAYLOAD_BITS_DEFAULT-1:0] payload_t;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC
  } cnt_op_e;

  function automatic logic xfer(input logic vld, input logic ack);
    return (vld == XFER_VLD) && (ack == XFER_ACK);
  endfunction

endpackage

// File: rtl/user_port_fifo_ram.sv
// Simple dual-port storage for user_port_fifo: one synchronous write port,
// one asynchronous read port.
module user_port_fifo_ram #(
  parameter int unsigned PAYLOAD_BITS = 32,
  parameter int unsigned DEPTH_BITS   = 4
) (
  input  logic                    clk_user,
  input  logic                    wr_en,
  input  logic [DEPTH_BITS-1:0]   wr_addr,
  input  logic [PAYLOAD_BITS-1:0] wr_data,
  input  logic [DEPTH_BITS-1:0]   rd_addr,
  output logic [PAYLOAD_BITS-1:0] rd_data
);

  localparam int unsigned DEPTH = 2**DEPTH_BITS;

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk_user) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/user_port_fifo.sv
// Elastic FWFT buffer for one user-side stream port with registered ack/valid/data.
// Build option USER_PORT_FIFO_OVERFLOW_CHECK_EN enables the sticky overflow_err detector.
module user_port_fifo
  import leaf_port_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS       = PAYLOAD_BITS_DEFAULT,
  parameter int unsigned DEPTH_BITS         = 4,
  parameter int unsigned ALMOST_FULL_MARGIN = 2
) (
  input  logic                    clk_user,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    vld_in,
  output logic                    ack_out,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    vld_out,
  input  logic                    ack_in,
  output logic                    almost_full,
  output logic                    overflow_err
);

  localparam int unsigned         DEPTH     = 2**DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] AF_MARGIN = (DEPTH_BITS+1)'(ALMOST_FULL_MARGIN);

  logic [DEPTH_BITS-1:0]   wr_ptr;
  logic [DEPTH_BITS-1:0]   rd_ptr;
  logic [DEPTH_BITS:0]     count;
  logic [DEPTH_BITS:0]     count_nxt;
  logic [DEPTH_BITS:0]     stored;
  logic                    push;
  logic                    pop;
  logic                    load;
  logic                    stored_empty;
  logic [PAYLOAD_BITS-1:0] ram_rdata;
  cnt_op_e                 cnt_op;

  user_port_fifo_ram #(
    .PAYLOAD_BITS (PAYLOAD_BITS),
    .DEPTH_BITS   (DEPTH_BITS)
  ) u_ram (
    .clk_user (clk_user),
    .wr_en    (push),
    .wr_addr  (wr_ptr),
    .wr_data  (din),
    .rd_addr  (rd_ptr),
    .rd_data  (ram_rdata)
  );

  // Every push lands in the array; when the array holds nothing behind the output
  // register, din bypasses straight into it and rd_ptr steps past the same slot.
  always_comb begin
    push         = xfer(vld_in, ack_out);
    pop          = xfer(vld_out, ack_in);
    stored       = count - (DEPTH_BITS+1)'(vld_out);
    stored_empty = (stored == '0);
    load         = (pop || !vld_out) && (!stored_empty || push);

    cnt_op = CNT_HOLD;
    if (push && !pop) begin
      cnt_op = CNT_INC;
    end else if (pop && !push) begin
      cnt_op = CNT_DEC;
    end

    count_nxt = count;
    case (cnt_op)
      CNT_INC: count_nxt = count + 1'b1;
      CNT_DEC: count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk_user) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ack_out     <= 1'b0;
      vld_out     <= 1'b0;
      dout        <= '0;
      almost_full <= 1'b0;
    end else begin
      count       <= count_nxt;
      ack_out     <= (count_nxt != DEPTH_CNT);
      almost_full <= ((DEPTH_CNT - count_nxt) <= AF_MARGIN);
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr  <= rd_ptr + 1'b1;
        dout    <= stored_empty ? din : ram_rdata;
        vld_out <= 1'b1;
      end else if (pop) begin
        vld_out <= 1'b0;
      end
    end
  end

`ifdef USER_PORT_FIFO_OVERFLOW_CHECK_EN
  logic reset_done;

  // reset_done gates out the one cycle after reset where ack_out is still low.
  always_ff @(posedge clk_user) begin
    if (reset) begin
      reset_done   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      reset_done <= 1'b1;
      if (vld_in && !ack_out && reset_done) begin
        overflow_err <= 1'b1;
      end
    end
  end

  pop_nonempty_a : assert property (@(posedge clk_user) disable iff (reset)
    !(pop && (count == '0)));
`else
  assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_user_port_fifo.sv
// Self-checking bench for user_port_fifo: fill/drain vector table, then streaming,
// random stall, full-with-pop, overflow and mid-stream reset sequences.
module tb_user_port_fifo;

`ifdef USER_PORT_FIFO_OVERFLOW_CHECK_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic        clk_user = 1'b0;
  logic        reset;
  logic [31:0] din;
  logic        vld_in;
  logic        ack_out;
  logic [31:0] dout;
  logic        vld_out;
  logic        ack_in;
  logic        almost_full;
  logic        overflow_err;

  user_port_fifo #(
    .PAYLOAD_BITS       (32),
    .DEPTH_BITS         (4),
    .ALMOST_FULL_MARGIN (2)
  ) dut (
    .clk_user     (clk_user),
    .reset        (reset),
    .din          (din),
    .vld_in       (vld_in),
    .ack_out      (ack_out),
    .dout         (dout),
    .vld_out      (vld_out),
    .ack_in       (ack_in),
    .almost_full  (almost_full),
    .overflow_err (overflow_err)
  );

  always #5 clk_user = ~clk_user;

  typedef struct {
    logic        vld;
    logic [31:0] d;
    logic        ack;
    logic        e_ack;
    logic        e_vld;
    logic [31:0] e_dout;
    logic        e_af;
    logic        e_ovf;
  } vec_t;

  localparam int NVEC = 33;
  vec_t tbl [NVEC];

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic        last_push;
  logic        just_reset;
  logic        model_ovf;
  logic [31:0] q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: compare current outputs against the queue model, drive, then update model.
  task automatic cycle(input logic v, input logic [31:0] d, input logic a);
    logic push, pop, hold, ack_pre;
    logic [31:0] dprev;
    vld_in = v;
    din    = d;
    ack_in = a;
    check("ack_out", ack_out, (!just_reset && q.size() != 16));
    check("vld_out", vld_out, (q.size() != 0));
    if (q.size() != 0) check("dout", dout, q[0]);
    check("almost_full", almost_full, (q.size() >= 14));
    check("overflow_err", overflow_err, model_ovf);
    ack_pre = ack_out;
    push    = v && ack_out;
    pop     = vld_out && a;
    hold    = vld_out && !a;
    dprev   = dout;
    @(posedge clk_user);
    #1;
    if (pop && q.size() != 0) begin
      q.delete(0);
      pops++;
    end
    if (push) q.push_back(d);
    if (v && !ack_pre && !just_reset && OVF_EN) model_ovf = 1'b1;
    just_reset = 1'b0;
    last_push  = push;
    if (hold) check("dout_stable", dout, dprev);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pushed;
    int p0;

    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{1'b1, 32'(i + 1), 1'b0, (i != 15), 1'b1, 32'h1, (i >= 13), 1'b0};
    end
    tbl[16] = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 32'h1, 1'b1, OVF_EN};
    for (int j = 1; j <= 16; j++) begin
      tbl[16 + j] = '{1'b0, 32'h0, 1'b1, 1'b1, (j < 16),
                      (j < 16) ? 32'(j + 1) : 32'd16, (j <= 2), OVF_EN};
    end

    reset  = 1'b1;
    vld_in = 1'b0;
    din    = '0;
    ack_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_user);
      #1;
      check("rst_ack", ack_out, 0);
      check("rst_vld", vld_out, 0);
      check("rst_dout", dout, 0);
      check("rst_af", almost_full, 0);
      check("rst_ovf", overflow_err, 0);
    end
    reset      = 1'b0;
    just_reset = 1'b1;
    model_ovf  = 1'b0;
    q.delete();
    cycle(1'b0, 32'h0, 1'b0);
    check("rst_exit_ack", ack_out, 1);

    // Fill/drain table
    for (int i = 0; i < NVEC; i++) begin
      vld_in = tbl[i].vld;
      din    = tbl[i].d;
      ack_in = tbl[i].ack;
      @(posedge clk_user);
      #1;
      check($sformatf("tbl%0d_ack", i), ack_out, tbl[i].e_ack);
      check($sformatf("tbl%0d_vld", i), vld_out, tbl[i].e_vld);
      check($sformatf("tbl%0d_dout", i), dout, tbl[i].e_dout);
      check($sformatf("tbl%0d_af", i), almost_full, tbl[i].e_af);
      check($sformatf("tbl%0d_ovf", i), overflow_err, tbl[i].e_ovf);
    end
    q.delete();
    just_reset = 1'b0;
    model_ovf  = OVF_EN;

    // Full with simultaneous pop
    for (int i = 0; i < 16; i++) cycle(1'b1, 32'h2000 + 32'(i), 1'b0);
    check("full_ack_low", ack_out, 0);
    cycle(1'b1, 32'hBAD0_0001, 1'b1);
    check("full_pop_ack_next", ack_out, 1);
    cycle(1'b1, 32'h2010, 1'b0);
    check("full_refill_ack", ack_out, 0);
    check("full_refill_cnt", q.size(), 16);
    for (int i = 0; i < 17; i++) cycle(1'b0, 32'h0, 1'b1);
    check("full_drain_empty", vld_out, 0);

    // Streaming
    p0 = pops;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 32'h1000 + 32'(i), 1'b1);
      if (i == 0) check("stream_first_vld", vld_out, 1);
      check("stream_count", (q.size() <= 1), 1);
    end
    cycle(1'b0, 32'h0, 1'b1);
    check("stream_words", pops - p0, 100);

    // Random stall
    pushed = 0;
    for (int n = 0; n < 60000 && pushed < 10000; n++) begin
      cycle(1'($urandom_range(0, 1)), 32'hC000_0000 + 32'(pushed), 1'($urandom_range(0, 1)));
      if (last_push) pushed++;
    end
    check("rand_pushed", pushed, 10000);
    for (int n = 0; n < 40 && q.size() != 0; n++) cycle(1'b0, 32'h0, 1'b1);
    check("rand_drained", q.size(), 0);
    check("rand_vld_low", vld_out, 0);

    // Overflow while full
    for (int i = 0; i < 16; i++) cycle(1'b1, 32'h3000 + 32'(i), 1'b0);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
    check("ovf_set", overflow_err, OVF_EN);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);
    check("ovf_sticky", overflow_err, OVF_EN);
    check("hold8", q.size(), 8);

    // Mid-stream reset with 8 words held
    reset  = 1'b1;
    vld_in = 1'b0;
    ack_in = 1'b0;
    @(posedge clk_user);
    #1;
    check("mrst_vld", vld_out, 0);
    check("mrst_ack", ack_out, 0);
    check("mrst_ovf", overflow_err, 0);
    check("mrst_af", almost_full, 0);
    reset      = 1'b0;
    just_reset = 1'b1;
    model_ovf  = 1'b0;
    q.delete();
    cycle(1'b1, 32'hA5A5_A5A5, 1'b0);
    check("mrst_ack_next", ack_out, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'hA5A5_A5A5, 1'b0);
      if (i == 0) check("mrst_first_word", dout, 32'hA5A5_A5A5);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);
    check("mrst_drained", vld_out, 0);
    check("mrst_ovf_clear", overflow_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/user_port_fifo.md
Name: user_port_fifo

Overview:
- Elastic buffer for one 32-bit user-side stream port of a leaf shell, in the clk_user domain.
- Instantiated once per port, between leaf_interface (dout_leaf_interface2user_N / vld / ack) and the user kernel, or mirrored on the kernel-to-interface return path.
- Absorbs kernel stalls so the interface's ack is not combinationally dependent on kernel logic.
- Provides registered valid/data to the downstream consumer.

Parameters:
- PAYLOAD_BITS, 32, width of each data word.
- DEPTH_BITS, 4, log2 of buffer depth. DEPTH = 2**DEPTH_BITS = 16 entries. Legal range is 1..10.
- ALMOST_FULL_MARGIN, 2, almost_full asserts when free entries <= this value. Must be < DEPTH.

Ports:
- clk_user  in  1  user clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- din  in  PAYLOAD_BITS  write data from upstream.
- vld_in  in  1  upstream data valid.
- ack_out  out  1  ready to upstream; a word transfers on a cycle with vld_in && ack_out.
- dout  out  PAYLOAD_BITS  read data to downstream.
- vld_out  out  1  dout valid.
- ack_in  in  1  downstream ready; a word transfers on a cycle with vld_out && ack_in.
- almost_full  out  1  early backpressure hint for a registered upstream.
- overflow_err  out  1  sticky flag: vld_in && !ack_out observed while the fifo reported reset complete. Diagnostic only.

Behaviour:
- Storage: DEPTH x PAYLOAD_BITS array, write pointer wr_ptr, read pointer rd_ptr, occupancy count. Pointers are DEPTH_BITS wide and wrap naturally mod DEPTH. count is DEPTH_BITS+1 wide.
- Reset values (on a clk_user edge with reset=1):
  - wr_ptr, rd_ptr and count = 0.
  - ack_out = 0, vld_out = 0, dout = 0, almost_full = 0, overflow_err = 0.
- Reset exit: ack_out is a register. It rises on the first edge after reset deasserts, so the first write can occur 1 cycle after reset low.
- Reset mid-operation: all contents are discarded immediately. The partially drained stream is lost and vld_out drops on the reset edge.
- Push: occurs when vld_in && ack_out. The word is written at wr_ptr, and wr_ptr increments.
- Pop: occurs when vld_out && ack_in. rd_ptr increments.
- count update:
  - push only: count+1.
  - pop only: count-1.
  - both: count unchanged.
- ack_out is registered: next ack_out = (next_count != DEPTH). When full, ack_out=0. A same-cycle pop while full does not raise ack in that cycle; it raises ack on the following cycle.
- Read side is first-word-fall-through with a registered output stage:
  - vld_out = 1 whenever the output register holds a word.
  - On pop, or when the output register is empty and storage is nonempty, the register loads the next word.
  - Minimum latency from push to vld_out is 1 cycle when the fifo is empty.
  - dout holds stable while vld_out && !ack_in.
  - When empty, dout keeps its last value and vld_out=0.
- Throughput: sustained 1 word/cycle with vld_in=1 and ack_in=1 continuously. There are no bubbles after the initial 1-cycle fill latency.
- Total capacity: DEPTH words, including the word in the output register. count counts all held words.
- almost_full = (DEPTH - count) <= ALMOST_FULL_MARGIN. Registered, updated with count.
- overflow_err sets on vld_in && !ack_out && !reset only if the OVERFLOW_CHECK_EN build is used. Otherwise it is tied 0. It clears only on reset.
- Word order is strictly FIFO. Data is never dropped or duplicated.

Optional Feature:
- Macro: USER_PORT_FIFO_OVERFLOW_CHECK_EN.
- Defined: overflow_err behaves as above. Additionally, a pop with count==0 is impossible by construction and is asserted in simulation.
- Undefined: overflow_err is constant 0 and no detection logic is synthesised.

Decomposition:
- Shared package leaf_port_pkg holds:
  - PAYLOAD_BITS default (32).
  - The vld/ack transfer-rule constants.
  - A typedef for the payload word.
- One natural sub-module: user_port_fifo_ram (simple dual-port DEPTH x PAYLOAD_BITS array, 1 write port, 1 async-read or registered-read port). Pointer, count and handshake logic stay in the top.

Test Plan:
- Fill/drain:
  - Stimulus: reset for 3 cycles, then push 0x00000001..0x00000010 with ack_in=0.
  - Required: ack_out drops after the 16th push, almost_full asserts when count reaches 14, and a 17th vld_in is not accepted. Then set ack_in=1: 16 words emerge in order on consecutive cycles, then vld_out=0.
- Streaming:
  - Stimulus: vld_in=1 and ack_in=1 for 100 cycles with incrementing data.
  - Required: the first vld_out appears 1 cycle after the first push, 100 words arrive in order with no gaps, and count stays at most 1.
- Random stall:
  - Stimulus: 10,000 words with vld_in and ack_in each randomly 50% high.
  - Required: the scoreboard matches exactly, and dout is stable while vld_out && !ack_in.
- Full with simultaneous pop:
  - Stimulus: count=16, then pulse ack_in for 1 cycle while vld_in=1.
  - Required: ack_out is still 0 that cycle and 1 the next cycle, and count returns to 16 after the next push.
- Mid-stream reset:
  - Stimulus: hold 8 words, assert reset for 1 cycle.
  - Required: vld_out=0 and ack_out=0 that cycle, ack_out=1 on the next cycle, and the words pushed afterwards (0xA5A5A5A5) emerge first with no stale data.
- Overflow flag:
  - Stimulus: with USER_PORT_FIFO_OVERFLOW_CHECK_EN defined, drive vld_in=1 while full.
  - Required: overflow_err=1 the next cycle and it stays 1 until reset. Without the macro it stays 0.
